// File: rtl/mmcm_ps_sequencer_pkg.sv
// mmcm_ps_pkg: state and result encodings shared with the digitizer config register map
package mmcm_ps_pkg;
  typedef enum logic [2:0] {IDLE, PULSE, WAIT, SETTLE, FINISH} state_e;
  typedef enum logic [1:0] {RES_OK, RES_UNLOCK, RES_TIMEOUT, RES_ABORT} res_e;
endpackage

// File: rtl/mmcm_ps_sequencer_if.sv
// mmcm_ps_sequencer_if: host command/status plus MMCM dynamic phase-shift signals
interface mmcm_ps_sequencer_if #(
  parameter int cw = 16
);
  logic          start, abort, mmcm_locked, psdone;
  logic          psen, psincdec, busy, done;
  logic [cw-1:0] steps, remaining, position;
  logic [1:0]    result;
  modport master (
    output start, steps, abort, mmcm_locked, psdone,
    input  psen, psincdec, busy, done, result, remaining, position
  );
  modport slave (
    input  start, steps, abort, mmcm_locked, psdone,
    output psen, psincdec, busy, done, result, remaining, position
  );
endinterface

// File: rtl/mmcm_ps_sequencer.sv
// mmcm_ps_sequencer: turns a signed step request into paced psen/psdone pairs on the MMCM,
// tracking net phase position and reporting lock loss, psdone timeout and abort.
module mmcm_ps_sequencer
  import mmcm_ps_pkg::*;
#(
  parameter int cw     = 16,
  parameter int tw     = 8,
  parameter int settle = 4
) (
  input logic                lb_clk,
  input logic                lb_rst_n,
  mmcm_ps_sequencer_if.slave host
);
  localparam logic [tw-1:0] TMAX = '1;
  localparam logic [tw-1:0] SMAX = tw'(settle);
  state_e        state_q, state_d;
  res_e          res_q, res_d;
  logic          dir_q, dir_d, abort_q, abort_d, abort_p, active;
  logic          psen_q, psincdec_q, busy_q, done_q;
  logic [cw-1:0] rem_q, rem_d, pos_q, pos_d;
  logic [tw-1:0] cnt_q, cnt_d;
  assign active  = state_q inside {PULSE, WAIT, SETTLE};
  assign abort_p = abort_q | (host.abort & busy_q);
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q + tw'(1);
    case (state_q)
      IDLE: if (host.start) begin
        dir_d   = ~host.steps[cw-1];
        rem_d   = host.steps[cw-1] ? -host.steps : host.steps;
        state_d = (host.steps == '0 || !host.mmcm_locked) ? FINISH : PULSE;
        res_d   = (host.steps != '0 && !host.mmcm_locked) ? RES_UNLOCK : RES_OK;
      end
      // the counter starts at 1 here so the timeout lands 2^tw-1 cycles after psen
      PULSE: begin
        cnt_d   = tw'(1);
        state_d = WAIT;
      end
      WAIT: if (host.psdone) begin
        pos_d   = dir_q ? pos_q + cw'(1) : pos_q - cw'(1);
        rem_d   = rem_q - cw'(1);
        cnt_d   = '0;
        state_d = (rem_q == cw'(1) || abort_p) ? FINISH : SETTLE;
        res_d   = (rem_q != cw'(1) && abort_p) ? RES_ABORT : res_q;
      end else if (cnt_d == TMAX) begin
        state_d = FINISH;
        res_d   = RES_TIMEOUT;
      end
      SETTLE: if (abort_p) begin
        state_d = FINISH;
        res_d   = RES_ABORT;
      end else if (cnt_q == SMAX) state_d = PULSE;
      default: state_d = IDLE;
    endcase
    // lock loss overrides every other outcome and freezes the step count
    if (!host.mmcm_locked) begin
      pos_d = '0;
      if (active) begin
        state_d = FINISH;
        res_d   = RES_UNLOCK;
        rem_d   = rem_q;
      end
    end
    abort_d = abort_p & (state_d inside {PULSE, WAIT, SETTLE});
  end
  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      state_q    <= IDLE;
      res_q      <= RES_OK;
      dir_q      <= 1'b0;
      abort_q    <= 1'b0;
      rem_q      <= '0;
      pos_q      <= '0;
      cnt_q      <= '0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      dir_q      <= dir_d;
      abort_q    <= abort_d;
      rem_q      <= rem_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      psen_q     <= state_d == PULSE;
      psincdec_q <= (state_d == PULSE) ? dir_d : psincdec_q;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == FINISH;
    end
  end
  assign host.psen      = psen_q;
  assign host.psincdec  = psincdec_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.result    = res_q;
  assign host.remaining = rem_q;
  assign host.position  = pos_q;
endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// tb_mmcm_ps_sequencer: random phase-shift commands against an outcome model, scoreboarded on done
module tb_mmcm_ps_sequencer;
  localparam int CW = 16;
  typedef struct {
    int         res;
    logic [15:0] pos;
    logic [15:0] rem;
    logic [15:0] rem0;
    int         npsen;
    bit         dir;
    int         gap;
    int         lat;
  } exp_t;
  logic clk = 0, rst_n;
  int   cyc = 0, checks = 0, errors = 0, start_cyc = 0, model_pos = 0;
  int   plan_kind = 0, plan_k = 0, plan_lat = 0;
  bit   plan_same = 0, stim_unlock = 0;
  exp_t q[$];
  mmcm_ps_sequencer_if #(.cw(CW)) bus ();
  mmcm_ps_sequencer #(.cw(CW), .tw(8), .settle(4)) dut (
    .lb_clk(clk), .lb_rst_n(rst_n), .host(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, x, cyc);
    end
  endtask
  task automatic rst_chk();
    chk("rst_psen", bus.psen, 0);
    chk("rst_psincdec", bus.psincdec, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_remaining", bus.remaining, 0);
    chk("rst_position", bus.position, 0);
  endtask
  // MMCM model: psdone some cycles after each psen, plus planned abort / lock drop / withheld psdone
  initial begin
    int step_no, t_done, t_abort, t_lock, d, o;
    bit drop;
    step_no = 0; t_done = -1; t_abort = -1; t_lock = -1; drop = 0;
    bus.psdone = 0; bus.abort = 0; bus.mmcm_locked = 1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        step_no = 0; drop = 0; t_done = -1; t_abort = -1; t_lock = -1;
      end else begin
        if (bus.done) begin step_no = 0; drop = 0; end
        if (bus.psen) begin
          step_no++;
          d = plan_lat > 0 ? plan_lat : int'($urandom_range(1, 20));
          t_done = (plan_kind == 3 && step_no == plan_k) ? -1 : cyc + d;
          if (step_no == plan_k) begin
            o = plan_same ? d : int'($urandom_range(0, d));
            if (plan_kind == 1) t_abort = cyc + o;
            if (plan_kind == 2) t_lock = cyc + o;
          end
        end
        if (cyc == t_lock) drop = 1;
      end
      bus.psdone = cyc == t_done;
      bus.abort = cyc == t_abort;
      bus.mmcm_locked = !(drop || stim_unlock);
    end
  end
  // monitor / scoreboard
  initial begin
    int npsen, last_psen;
    bit prev_psen;
    exp_t e;
    npsen = 0; last_psen = 0; prev_psen = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rst_chk(); q.delete(); npsen = 0; prev_psen = 0;
      end else begin
        if (bus.psen) begin
          chk("psen_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            if (npsen == 0) chk("remaining_at_first_psen", bus.remaining, q[0].rem0);
            chk("psincdec", bus.psincdec, q[0].dir);
          end
          chk("psen_width", prev_psen, 0);
          npsen++;
          last_psen = cyc;
        end
        prev_psen = bus.psen;
        if (bus.done) begin
          chk("done_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("result", bus.result, e.res);
            chk("position", bus.position, e.pos);
            chk("remaining", bus.remaining, e.rem);
            chk("psen_count", npsen, e.npsen);
            chk("busy_at_done", bus.busy, 1);
            if (e.gap >= 0) chk("timeout_gap", cyc - last_psen, e.gap);
            if (e.lat >= 0) chk("done_latency", cyc - start_cyc, e.lat);
          end
          npsen = 0;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        rst_chk(); q.delete(); npsen = 0; prev_psen = 0;
      end
    end
  end
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  // kind: 0 plain, 1 abort during step k, 2 lock lost during step k, 3 psdone withheld on step k
  task automatic run_op(input int n, input int kind, input int k, input bit same,
                        input int lat, input bit poke, input bit rst_mid);
    int mag, sd, ndone, w;
    exp_t e;
    mag = n < 0 ? -n : n;
    sd = n < 0 ? -1 : 1;
    e.dir = n >= 0; e.rem0 = 16'(mag); e.gap = -1; e.lat = -1;
    e.res = 0; e.npsen = mag; ndone = mag;
    if (n != 0 && stim_unlock) begin
      e.res = 1; e.npsen = 0; ndone = 0; e.lat = 1; model_pos = 0;
    end else if (n == 0) begin
      e.npsen = 0; ndone = 0; e.lat = 1;
    end else if (kind == 1) begin
      e.res = k < mag ? 3 : 0; e.npsen = k; ndone = k;
    end else if (kind == 2) begin
      e.res = 1; e.npsen = k; ndone = k - 1;
    end else if (kind == 3) begin
      e.res = 2; e.npsen = k; ndone = k - 1; e.gap = 255;
    end
    if (e.res == 1) model_pos = 0;
    else model_pos += sd * ndone;
    e.pos = 16'(model_pos);
    e.rem = 16'(mag - ndone);
    plan_kind = kind; plan_k = k; plan_same = same; plan_lat = lat;
    q.push_back(e);
    bus.start = 1; bus.steps = 16'(n); start_cyc = cyc;
    wait_cycles(1);
    bus.start = 0;
    if (poke) begin
      wait_cycles(4);
      bus.start = 1; bus.steps = 16'(7);
      wait_cycles(1);
      bus.start = 0;
    end
    if (rst_mid) begin
      for (w = 0; bus.remaining != 16'(mag - 1) && w < 3000; w++) wait_cycles(1);
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      model_pos = 0;
      wait_cycles(3);
    end else begin
      for (w = 0; !bus.done && w < 3000; w++) wait_cycles(1);
      if (!bus.done) begin
        $display("FAIL watchdog: no done after %0d cycles, expected done=1", w);
        $fatal(1);
      end
      wait_cycles(25);
    end
  endtask
  initial begin
    int n, r, kind, mag;
    rst_n = 1; bus.start = 0; bus.steps = '0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    wait_cycles(3);
    run_op(3, 0, 0, 0, 12, 1, 0);
    run_op(1, 0, 0, 0, 0, 0, 0);
    run_op(3, 0, 0, 0, 0, 0, 1);
    run_op(-32768, 1, 2, 1, 0, 0, 0);
    run_op(4, 2, 2, 1, 0, 0, 0);
    run_op(0, 0, 0, 0, 0, 0, 0);
    stim_unlock = 1;
    wait_cycles(2);
    run_op(-5, 0, 0, 0, 0, 0, 0);
    stim_unlock = 0;
    wait_cycles(2);
    run_op(3, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      mag = int'($urandom_range(1, 5));
      n = $urandom_range(0, 1) ? -mag : mag;
      r = int'($urandom_range(0, 9));
      kind = r < 5 ? 0 : r < 7 ? 1 : r < 9 ? 2 : 3;
      run_op(n, kind, int'($urandom_range(1, mag)), 1'($urandom_range(0, 1)), 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
